// File: rtl/player_mover_if.sv
// player_mover_if: the pixel-coordinate bus shared by the player mover, the
// ghost chasers and the renderer.
//   btn        4    synchronised level buttons {d,a,s,w} = bits [3:0]
//   tilemap    768  1 = wall; index = 32*(y/20) + x/20
//   isOver     1    collision flag from the ghosts
//   Player_x   10   player top-left X, pixels
//   Player_y   9    player top-left Y, pixels
//   direction  2    current heading: 0 w, 1 s, 2 a, 3 d
//   moving     1    last step advanced the position
//   state      2    0 IDLE, 1 MOVE, 2 STOP, 3 DEAD
// master drives buttons/map/collision; slave (the mover) drives the position.
interface player_mover_if;
  logic [3:0]   btn;
  logic [767:0] tilemap;
  logic         isOver;
  logic [9:0]   Player_x;
  logic [8:0]   Player_y;
  logic [1:0]   direction;
  logic         moving;
  logic [1:0]   state;

  modport master (
    output btn, tilemap, isOver,
    input  Player_x, Player_y, direction, moving, state
  );

  modport slave (
    input  btn, tilemap, isOver,
    output Player_x, Player_y, direction, moving, state
  );
endinterface

// File: rtl/player_mover.sv
// player_mover: Pac-Man movement controller. Turns the four direction
// buttons into a top-left pixel position that steps SPEED pixels every
// TICK_DIV clocks through a 32x24 tile maze of 20x20-pixel tiles.
// Turn requests are buffered for PEND_TICKS steps and only taken on tile
// alignment (reversals are taken anywhere). Freezes for good on isOver.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    player_mover_if.slave: btn/tilemap/isOver in,
//          Player_x/Player_y/direction/moving/state out (all registered)
module player_mover #(
  parameter int START_X    = 300,
  parameter int START_Y    = 340,
  parameter int BOUND_X0   = 0,
  parameter int BOUND_X1   = 620,
  parameter int BOUND_Y0   = 0,
  parameter int BOUND_Y1   = 460,
  parameter int SPEED      = 5,
  parameter int TICK_DIV   = 4,
  parameter int PEND_TICKS = 8
) (
  input logic           clk,
  input logic           reset,
  player_mover_if.slave bus
);

  localparam int TILE = 20;
  localparam int COLS = 32;
  localparam int MAP_W = COLS * TILE;
  localparam int MAP_H = 24 * TILE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    STOP = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [1:0] DIR_W = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_A = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  // A pixel is free when it lies on the map and its tile is not a wall.
  function automatic logic tile_free(input int px, input int py, input logic [767:0] map);
    int idx;
    if (px < 0 || px >= MAP_W || py < 0 || py >= MAP_H) begin
      return 1'b0;
    end else begin
      idx = (py / TILE) * COLS + (px / TILE);
      return !map[10'(idx)];
    end
  endfunction

  // One step in direction d stays inside the bounds and both leading-edge
  // corners of the 20x20 box land on free tiles. Bounds are compared in
  // int arithmetic so a step off the low edge cannot wrap.
  function automatic logic movable(input logic [1:0] d, input int x, input int y,
                                   input logic [767:0] map);
    logic ok;
    case (d)
      DIR_W: ok = (y >= BOUND_Y0 + SPEED) && tile_free(x, y - SPEED, map)
                  && tile_free(x + TILE - 1, y - SPEED, map);
      DIR_S: ok = (y + SPEED <= BOUND_Y1) && tile_free(x, y + SPEED + TILE - 1, map)
                  && tile_free(x + TILE - 1, y + SPEED + TILE - 1, map);
      DIR_A: ok = (x >= BOUND_X0 + SPEED) && tile_free(x - SPEED, y, map)
                  && tile_free(x - SPEED, y + TILE - 1, map);
      DIR_D: ok = (x + SPEED <= BOUND_X1) && tile_free(x + SPEED + TILE - 1, y, map)
                  && tile_free(x + SPEED + TILE - 1, y + TILE - 1, map);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [9:0] x_r;
  logic [8:0] y_r;
  logic [1:0] dir_r;
  logic       moving_r;
  state_t     state_r;
  logic [7:0] tick_r;
  logic [1:0] pend_dir_r;
  logic       pend_valid_r;
  logic [7:0] pend_cnt_r;

  logic       step_en_s;
  logic       press_s;
  logic [1:0] req_dir_s;
  logic       turn_ok_s;
  logic       can_step_s;
  logic [1:0] eff_dir_s;
  logic [9:0] nx_s;
  logic [8:0] ny_s;

  // Step timing, button decode, turn decision and next position.
  always_comb begin
    step_en_s = (tick_r == 8'(TICK_DIV - 1));
    press_s   = |bus.btn;
    // w > s > a > d
    if (bus.btn[0]) begin
      req_dir_s = DIR_W;
    end else if (bus.btn[1]) begin
      req_dir_s = DIR_S;
    end else if (bus.btn[2]) begin
      req_dir_s = DIR_A;
    end else begin
      req_dir_s = DIR_D;
    end
    // A reversal is the same axis, opposite sign: heading codes differ in bit 0 only.
    turn_ok_s = pend_valid_r
                && movable(pend_dir_r, int'(x_r), int'(y_r), bus.tilemap)
                && ((((int'(x_r) % TILE) == 0) && ((int'(y_r) % TILE) == 0))
                    || (pend_dir_r == (dir_r ^ 2'b01)));
    eff_dir_s  = turn_ok_s ? pend_dir_r : dir_r;
    can_step_s = turn_ok_s || movable(dir_r, int'(x_r), int'(y_r), bus.tilemap);
    nx_s = x_r;
    ny_s = y_r;
    case (eff_dir_s)
      DIR_W:   ny_s = 9'(int'(y_r) - SPEED);
      DIR_S:   ny_s = 9'(int'(y_r) + SPEED);
      DIR_A:   nx_s = 10'(int'(x_r) - SPEED);
      DIR_D:   nx_s = 10'(int'(x_r) + SPEED);
      default: nx_s = x_r;
    endcase
  end

  // Movement FSM with tick divider, turn buffer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r          <= 10'(START_X);
      y_r          <= 9'(START_Y);
      dir_r        <= DIR_W;
      moving_r     <= 1'b0;
      state_r      <= IDLE;
      tick_r       <= 8'd0;
      pend_dir_r   <= DIR_W;
      pend_valid_r <= 1'b0;
      pend_cnt_r   <= 8'd0;
    end else begin
      tick_r <= step_en_s ? 8'd0 : tick_r + 8'd1;
      if (state_r == DEAD || bus.isOver) begin
        // Collision wins over any step in the same cycle; everything freezes.
        state_r  <= DEAD;
        moving_r <= 1'b0;
      end else begin
        if (press_s) begin
          pend_dir_r   <= req_dir_s;
          pend_valid_r <= 1'b1;
          pend_cnt_r   <= 8'(PEND_TICKS);
        end else if (step_en_s) begin
          if (pend_cnt_r != 8'd0) begin
            pend_cnt_r <= pend_cnt_r - 8'd1;
          end else begin
            pend_cnt_r <= 8'd0;
          end
          if (pend_cnt_r <= 8'd1 || (turn_ok_s && state_r != IDLE)) begin
            pend_valid_r <= 1'b0;
          end else begin
            pend_valid_r <= pend_valid_r;
          end
        end else begin
          pend_cnt_r <= pend_cnt_r;
        end

        case (state_r)
          IDLE: begin
            if (press_s) begin
              state_r <= MOVE;
              dir_r   <= req_dir_s;
            end else begin
              state_r <= IDLE;
            end
          end
          MOVE, STOP: begin
            if (step_en_s) begin
              if (turn_ok_s) begin
                dir_r <= pend_dir_r;
              end else begin
                dir_r <= dir_r;
              end
              if (can_step_s) begin
                x_r      <= nx_s;
                y_r      <= ny_s;
                moving_r <= 1'b1;
                state_r  <= MOVE;
              end else begin
                moving_r <= 1'b0;
                state_r  <= STOP;
              end
            end else begin
              state_r <= state_r;
            end
          end
          default: state_r <= DEAD;
        endcase
      end
    end
  end

  assign bus.Player_x  = x_r;
  assign bus.Player_y  = y_r;
  assign bus.direction = dir_r;
  assign bus.moving    = moving_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: expected outputs are pushed to a
// scoreboard queue as stimulus is applied and popped when the step lands.
module tb_player_mover;

  logic clk = 1'b0;
  logic reset;
  player_mover_if bus ();

  player_mover dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic       mv;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int ph     = 0;  // posedges since reset release, modulo the tick divider

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed = passed + 1;
    else begin
      fails++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int x, input int y, input int dir,
                      input int mv, input int st);
    exp_t e;
    e.tag = tag; e.x = 10'(x); e.y = 9'(y); e.dir = 2'(dir); e.mv = 1'(mv); e.st = 2'(st);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) passed = passed + 1;
    else begin
      fails++;
      $error("FAIL scoreboard observed empty expected entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, "x",     32'(bus.Player_x),  32'(e.x));
      chk(e.tag, "y",     32'(bus.Player_y),  32'(e.y));
      chk(e.tag, "dir",   32'(bus.direction), 32'(e.dir));
      chk(e.tag, "mv",    32'(bus.moving),    32'(e.mv));
      chk(e.tag, "state", 32'(bus.state),     32'(e.st));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    ph = (ph + n) % 4;
  endtask

  // Advance to just past the next step edge.
  task automatic next_step();
    cyc((ph == 0) ? 4 : 4 - ph);
  endtask

  task automatic press(input logic [3:0] b);
    bus.btn = b;
    cyc(1);
    bus.btn = 4'd0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset       = 1'b0;
    bus.btn     = 4'd0;
    bus.isOver  = 1'b0;
    bus.tilemap = '0;
    @(negedge clk);
    push(tag, 300, 340, 0, 0, 0);
    check_out();
    reset = 1'b1;
    ph    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.btn     = 4'd0;
    bus.isOver  = 1'b0;
    bus.tilemap = '0;

    // 1) idle after reset for 100 cycles
    do_reset("reset");
    for (int i = 0; i < 10; i++) begin
      push("idle", 300, 340, 0, 0, 0);
      cyc(10);
      check_out();
    end

    // 2) press d: enters MOVE at once, then +5 per step
    press(4'b1000);
    push("start_d", 300, 340, 3, 0, 1);
    check_out();
    for (int i = 1; i <= 4; i++) begin
      push("run_d", 300 + 5 * i, 340, 3, 1, 1);
      next_step();
      check_out();
    end

    // 3) wall at tile (17,17) blocks at X=320, then turn w
    bus.tilemap[17 * 32 + 17] = 1'b1;
    push("blocked", 320, 340, 3, 0, 2);
    next_step();
    check_out();
    push("still_blocked", 320, 340, 3, 0, 2);
    next_step();
    check_out();
    press(4'b0001);
    push("turn_w", 320, 335, 0, 1, 1);
    next_step();
    check_out();

    // 4a) deferred turn taken at the next tile alignment
    do_reset("reset_defer");
    press(4'b1000);
    push("defer_305", 305, 340, 3, 1, 1);
    next_step();
    check_out();
    press(4'b0001);
    for (int i = 1; i <= 3; i++) begin
      push("defer_run", 305 + 5 * i, 340, 3, 1, 1);
      next_step();
      check_out();
    end
    push("defer_turn", 320, 335, 0, 1, 1);
    next_step();
    check_out();

    // 4b) request expires against a wall row above
    do_reset("reset_expire");
    for (int c = 0; c < 32; c++) bus.tilemap[16 * 32 + c] = 1'b1;
    press(4'b1000);
    next_step();
    press(4'b0001);
    for (int i = 1; i <= 8; i++) begin
      push("expire_run", 305 + 5 * i, 340, 3, 1, 1);
      next_step();
      check_out();
    end
    bus.tilemap = '0;
    repeat (3) next_step();
    push("expired_no_turn", 365, 340, 3, 1, 1);
    next_step();
    check_out();

    // 5) reversal at a non-aligned position
    do_reset("reset_rev");
    press(4'b1000);
    next_step();
    push("rev_310", 310, 340, 3, 1, 1);
    next_step();
    check_out();
    press(4'b0100);
    push("reversal", 305, 340, 2, 1, 1);
    next_step();
    check_out();

    // 6) collision freezes everything, buttons ignored
    bus.isOver = 1'b1;
    cyc(1);
    push("dead", 305, 340, 2, 0, 3);
    check_out();
    bus.isOver = 1'b0;
    bus.btn    = 4'b1000;
    repeat (3) next_step();
    bus.btn = 4'd0;
    push("dead_frozen", 305, 340, 2, 0, 3);
    check_out();

    // Left boundary: stops exactly at X=0
    do_reset("reset_bound");
    press(4'b0100);
    repeat (59) next_step();
    push("bound_0", 0, 340, 2, 1, 1);
    next_step();
    check_out();
    push("bound_stop", 0, 340, 2, 0, 2);
    next_step();
    check_out();

    // Asynchronous reset mid-move, observed before the next clock edge
    press(4'b1000);
    next_step();
    cyc(2);
    reset = 1'b0;
    #1;
    push("async_reset", 300, 340, 0, 0, 0);
    check_out();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
